// File: rtl/fifo_rd_stream_if.sv
// Read-port / stream bundle for fifo_rd_stream.
// master: the read controller (drives the FIFO read enable and the stream).
// slave : the surrounding FIFO plus stream consumer.
interface fifo_rd_stream_if #(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH_WIDTH = 10
);
   logic                   fifo_rd_en;
   logic [DATA_WIDTH-1:0]  fifo_rd_data;
   logic                   fifo_rd_empty;
   logic [DEPTH_WIDTH:0]   fifo_rd_water_level;
   logic                   flush;
   logic                   m_valid;
   logic [DATA_WIDTH-1:0]  m_data;
   logic                   m_last;
   logic                   m_ready;
   logic                   busy;

   modport master (
      output fifo_rd_en, m_valid, m_data, m_last, busy,
      input  fifo_rd_data, fifo_rd_empty, fifo_rd_water_level, flush, m_ready
   );

   modport slave (
      input  fifo_rd_en, m_valid, m_data, m_last, busy,
      output fifo_rd_data, fifo_rd_empty, fifo_rd_water_level, flush, m_ready
   );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side controller for the 1024x32 async FIFO: drains the FIFO read port
// (one-cycle read latency) into a valid/ready burst stream with a last marker.
// Reads are issued only while the 3-entry skid buffer plus the outstanding read
// leave room, so m_ready never feeds fifo_rd_en combinationally.
// Optional build macro FIFO_RD_STREAM_TIMEOUT_EN: starts a partial burst after
// TIMEOUT_CYCLES idle cycles with data below a full burst.
module fifo_rd_stream #(
   parameter int DATA_WIDTH     = 32,
   parameter int DEPTH_WIDTH    = 10,
   parameter int BURST_LEN      = 16,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic              rd_clk,
   input  logic              rd_rst,
   fifo_rd_stream_if.master  bus
);
   localparam int            CW       = DEPTH_WIDTH + 1;
   localparam logic [CW-1:0] LEN_FULL = CW'(BURST_LEN);
   localparam logic [CW-1:0] ONE      = CW'(1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t                 state, state_nxt;
   logic [CW-1:0]          len, len_nxt;
   logic [CW-1:0]          issue_cnt, beat_cnt;
   logic [1:0]             buf_cnt, wr_ptr, rd_ptr;
   logic                   inflight, inflight_last;
   logic [DATA_WIDTH-1:0]  buf_data [3];
   logic [2:0]             buf_last;
   logic [2:0]             occupancy;
   logic                   rd_en, start, done, push, pop, m_valid_int, timeout_hit;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   assign occupancy   = {1'b0, buf_cnt} + {2'b00, inflight};
   assign push        = inflight;
   assign m_valid_int = (buf_cnt != 2'd0);
   assign pop         = m_valid_int && bus.m_ready;

`ifdef FIFO_RD_STREAM_TIMEOUT_EN
   localparam int            TW       = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TO_ONE   = TW'(1);
   logic [TW-1:0] to_cnt;

   assign timeout_hit = (to_cnt == TO_LIMIT);

   // Count idle cycles spent holding a partial burst's worth of data
   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst)
         to_cnt <= '0;
      else if (state == IDLE && !bus.fifo_rd_empty &&
               bus.fifo_rd_water_level < LEN_FULL && !timeout_hit)
         to_cnt <= to_cnt + TO_ONE;
      else
         to_cnt <= '0;
   end
`else
   // Threshold only matters when the idle timeout is built in
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
   assign timeout_hit = 1'b0;
`endif

   // Burst start/finish decisions and read issue
   always_comb begin
      state_nxt = state;
      len_nxt   = len;
      start     = 1'b0;
      done      = 1'b0;
      rd_en     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.fifo_rd_water_level >= LEN_FULL) begin
               start   = 1'b1;
               len_nxt = LEN_FULL;
            end else if ((bus.flush || timeout_hit) && !bus.fifo_rd_empty) begin
               start   = 1'b1;
               len_nxt = (bus.fifo_rd_water_level == '0) ? ONE : bus.fifo_rd_water_level;
            end
            if (start)
               state_nxt = BURST;
         end
         BURST: begin
            rd_en = !bus.fifo_rd_empty && (issue_cnt < len) && (occupancy < 3'd3);
            done  = pop && (beat_cnt == len - ONE);
            if (done)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State and latched burst length
   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         state <= IDLE;
         len   <= '0;
      end else begin
         state <= state_nxt;
         len   <= len_nxt;
      end
   end

   // Reads issued / beats accepted in the current burst
   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         issue_cnt <= '0;
         beat_cnt  <= '0;
      end else if (start) begin
         issue_cnt <= '0;
         beat_cnt  <= '0;
      end else begin
         if (rd_en)
            issue_cnt <= issue_cnt + ONE;
         if (pop)
            beat_cnt <= beat_cnt + ONE;
      end
   end

   // Outstanding read: data appears on fifo_rd_data the following cycle
   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         inflight      <= rd_en;
         inflight_last <= rd_en && (issue_cnt == len - ONE);
      end
   end

   // Skid buffer pointers and fill count
   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         buf_cnt <= 2'd0;
         wr_ptr  <= 2'd0;
         rd_ptr  <= 2'd0;
      end else begin
         if (push)
            wr_ptr <= ptr_inc(wr_ptr);
         if (pop)
            rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   buf_cnt <= buf_cnt + 2'd1;
            2'b01:   buf_cnt <= buf_cnt - 2'd1;
            default: buf_cnt <= buf_cnt;
         endcase
      end
   end

   // Skid buffer storage; contents are qualified by buf_cnt so need no reset
   always_ff @(posedge rd_clk) begin
      if (push) begin
         buf_data[wr_ptr] <= bus.fifo_rd_data;
         buf_last[wr_ptr] <= inflight_last;
      end
   end

   assign bus.fifo_rd_en = rd_en;
   assign bus.m_valid    = m_valid_int;
   assign bus.m_data     = m_valid_int ? buf_data[rd_ptr] : '0;
   assign bus.m_last     = m_valid_int && buf_last[rd_ptr];
   assign bus.busy       = (state == BURST);
endmodule
